// File: rtl/cache_top_if.sv
// CPU-side request/response bus of the cache subsystem.
// The CPU side drives master; the cache drives slave.
interface cache_top_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] Address_cpu;
  logic [DATA_WIDTH-1:0] DOut_cpu;
  logic                  wr_rd_cpu;
  logic                  cs_cpu;
  logic                  rdy_cpu;
  logic [DATA_WIDTH-1:0] DIn_cpu;

  modport master (
    output Address_cpu, DOut_cpu, wr_rd_cpu, cs_cpu,
    input  rdy_cpu, DIn_cpu
  );

  modport slave (
    input  Address_cpu, DOut_cpu, wr_rd_cpu, cs_cpu,
    output rdy_cpu, DIn_cpu
  );
endinterface

// File: rtl/cache_top.sv
// Direct-mapped write-back cache: controller + tag array, SRAM data store, byte-wide SDRAM model.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.

// state     | meaning
// INIT      | one cycle after reset before accepting requests
// IDLE      | rdy_cpu high, waiting for cs_cpu
// COMPARE   | tag/valid lookup of the latched request
// WRITEBACK | 32 beats copying the dirty victim line to SDRAM
// ALLOCATE  | 32 beats filling the line from SDRAM
// ACCESS    | single-cycle read or write of the SRAM byte
module cache_controller #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH_SRAM = 8,
  parameter int TAG_SIZE        = 8,
  parameter int DEPTH           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  cache_top_if.slave                 cpu,
  input  logic [DATA_WIDTH-1:0]      sram_rdata,
  output logic [DATA_WIDTH-1:0]      cpu_wdata,
  output logic [ADDR_WIDTH-1:0]      Address_sdram,
  output logic                       wr_rd_sdram,
  output logic                       mstrb_sdram,
  output logic                       mux_sel,
  output logic                       demux_sel,
  output logic                       wen_sram,
  output logic [ADDR_WIDTH_SRAM-1:0] address_cache_ctrl_sram
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = ADDR_WIDTH - TAG_SIZE - IDX_W;

  typedef enum logic [2:0] {INIT, IDLE, COMPARE, WRITEBACK, ALLOCATE, ACCESS} state_t;

  state_t state, next_state;

  logic [TAG_SIZE+1:0]        cache_line [DEPTH];
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic                       wr_q;
  logic [DATA_WIDTH-1:0]      din_q;
  logic [OFF_W-1:0]           beat_cnt;
  logic [ADDR_WIDTH-1:0]      sdram_addr_q;
  logic [ADDR_WIDTH_SRAM-1:0] sram_addr_q;

  logic [TAG_SIZE-1:0] tag_q;
  logic [IDX_W-1:0]    index;
  logic [OFF_W-1:0]    offset;
  logic [OFF_W-1:0]    beat;
  logic [TAG_SIZE+1:0] entry;
  logic                hit;
  logic                last_beat;

  assign tag_q     = addr_q[ADDR_WIDTH-1 -: TAG_SIZE];
  assign index     = addr_q[OFF_W +: IDX_W];
  assign offset    = addr_q[OFF_W-1:0];
  // Beat counter runs down to terminal count; the ascending beat index is its complement.
  assign beat      = ~beat_cnt;
  assign last_beat = (beat_cnt == '0);
  assign entry     = cache_line[index];
  assign hit       = entry[TAG_SIZE+1] && (entry[TAG_SIZE-1:0] == tag_q);

  assign cpu.rdy_cpu = (state == IDLE);
  assign cpu.DIn_cpu = din_q;
  assign cpu_wdata   = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:      next_state = IDLE;
      IDLE:      if (cpu.cs_cpu) next_state = COMPARE;
      COMPARE: begin
        if (hit)                                         next_state = ACCESS;
        else if (entry[TAG_SIZE+1] && entry[TAG_SIZE])   next_state = WRITEBACK;
        else                                             next_state = ALLOCATE;
      end
      WRITEBACK: if (last_beat) next_state = ALLOCATE;
      ALLOCATE:  if (last_beat) next_state = ACCESS;
      ACCESS:    next_state = IDLE;
      default:   next_state = INIT;
    endcase
  end

  // Address outputs track the active state and otherwise replay their last value.
  always_comb begin
    Address_sdram           = sdram_addr_q;
    address_cache_ctrl_sram = sram_addr_q;
    wr_rd_sdram             = 1'b0;
    mstrb_sdram             = 1'b0;
    mux_sel                 = 1'b0;
    demux_sel               = 1'b0;
    wen_sram                = 1'b0;
    case (state)
      WRITEBACK: begin
        Address_sdram           = {entry[TAG_SIZE-1:0], index, beat};
        address_cache_ctrl_sram = {index, beat};
        wr_rd_sdram             = 1'b1;
        mstrb_sdram             = 1'b1;
        demux_sel               = 1'b1;
      end
      ALLOCATE: begin
        Address_sdram           = {tag_q, index, beat};
        address_cache_ctrl_sram = {index, beat};
        mstrb_sdram             = 1'b1;
        mux_sel                 = 1'b1;
        wen_sram                = 1'b1;
      end
      ACCESS: begin
        address_cache_ctrl_sram = {index, offset};
        wen_sram                = wr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      din_q        <= '0;
      beat_cnt     <= '0;
      sdram_addr_q <= '0;
      sram_addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) cache_line[i] <= '0;
    end else begin
      sdram_addr_q <= Address_sdram;
      sram_addr_q  <= address_cache_ctrl_sram;
      if (state == IDLE && cpu.cs_cpu) begin
        addr_q <= cpu.Address_cpu;
        data_q <= cpu.DOut_cpu;
        wr_q   <= cpu.wr_rd_cpu;
      end
      if (state == COMPARE || (state == WRITEBACK && last_beat))
        beat_cnt <= '1;
      else if (state == WRITEBACK || state == ALLOCATE)
        beat_cnt <= beat_cnt - 1'b1;
      // Line becomes valid only once the final byte has landed.
      if (state == ALLOCATE && last_beat)
        cache_line[index] <= {2'b10, tag_q};
      if (state == ACCESS) begin
        if (wr_q) cache_line[index][TAG_SIZE] <= 1'b1;
        else      din_q <= sram_rdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE) begin
      if (hit && hit_count != 16'hFFFF)    hit_count  <= hit_count + 16'd1;
      if (!hit && miss_count != 16'hFFFF)  miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

module cache_sram #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH_SRAM = 8,
  parameter int DEPTH           = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_WIDTH_SRAM-1:0] addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = ADDR_WIDTH_SRAM - IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH][2**OFF_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr[ADDR_WIDTH_SRAM-1 -: IDX_W]][addr[OFF_W-1:0]] <= wdata;
  end

  assign rdata = mem[addr[ADDR_WIDTH_SRAM-1 -: IDX_W]][addr[OFF_W-1:0]];
endmodule

module sdram_model #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Reset loads the known pattern byte[a] = a[7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i[ADDR_WIDTH-1:0]] <= i[DATA_WIDTH-1:0];
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

module cache_top #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH_SRAM = 8,
  parameter int TAG_SIZE        = 8,
  parameter int DEPTH           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  cache_top_if.slave                 cpu,
  output logic [ADDR_WIDTH-1:0]      Address_sdram,
  output logic                       wr_rd_sdram,
  output logic                       mstrb_sdram,
  output logic                       mux_sel,
  output logic                       demux_sel,
  output logic                       wen_sram,
  output logic [ADDR_WIDTH_SRAM-1:0] address_cache_ctrl_sram
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
`endif
);
  logic [DATA_WIDTH-1:0] sram_rdata, sram_wdata, sdram_rdata, sdram_wdata, cpu_wdata;

  assign sram_wdata  = mux_sel   ? sdram_rdata : cpu_wdata;
  assign sdram_wdata = demux_sel ? sram_rdata  : '0;

  cache_controller #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH_SRAM(ADDR_WIDTH_SRAM),
    .TAG_SIZE(TAG_SIZE), .DEPTH(DEPTH)
  ) controller (
    .clk(clk), .rst(rst), .cpu(cpu), .sram_rdata(sram_rdata), .cpu_wdata(cpu_wdata),
    .Address_sdram(Address_sdram), .wr_rd_sdram(wr_rd_sdram), .mstrb_sdram(mstrb_sdram),
    .mux_sel(mux_sel), .demux_sel(demux_sel), .wen_sram(wen_sram),
    .address_cache_ctrl_sram(address_cache_ctrl_sram)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  cache_sram #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH_SRAM(ADDR_WIDTH_SRAM), .DEPTH(DEPTH)
  ) cache_memory (
    .clk(clk), .we(wen_sram), .addr(address_cache_ctrl_sram),
    .wdata(sram_wdata), .rdata(sram_rdata)
  );

  sdram_model #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) sdram (
    .clk(clk), .rst(rst), .we(mstrb_sdram && wr_rd_sdram), .addr(Address_sdram),
    .wdata(sdram_wdata), .rdata(sdram_rdata)
  );
endmodule

// File: tb/tb_cache_top.sv
// Scoreboard bench for cache_top: requests push expected transaction summaries,
// a monitor pops and compares each time rdy_cpu returns high.
module tb_cache_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Address_sdram;
  logic        wr_rd_sdram, mstrb_sdram, mux_sel, demux_sel, wen_sram;
  logic [7:0]  address_cache_ctrl_sram;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_top_if cpu ();

  cache_top dut (
    .clk(clk), .rst(rst), .cpu(cpu),
    .Address_sdram(Address_sdram), .wr_rd_sdram(wr_rd_sdram), .mstrb_sdram(mstrb_sdram),
    .mux_sel(mux_sel), .demux_sel(demux_sel), .wen_sram(wen_sram),
    .address_cache_ctrl_sram(address_cache_ctrl_sram)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    int          busy;
    int          fills;
    logic [15:0] fill_first;
    int          wbs;
    logic [15:0] wb_first;
    int          wens;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] din, input int busy, input int fills,
                              input logic [15:0] ff, input int wbs, input logic [15:0] wf,
                              input int wens);
    exp_t e;
    e.din = din; e.busy = busy; e.fills = fills; e.fill_first = ff;
    e.wbs = wbs; e.wb_first = wf; e.wens = wens;
    return e;
  endfunction

  // Monitor: accumulate activity per request and compare when the cache returns to idle.
  initial begin
    int busy = 0, fills = 0, wbs = 0, wens = 0;
    logic [15:0] ff = '0, fl = '0, wf = '0, wl = '0;
    bit prev_rdy = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!cpu.rdy_cpu) busy++;
        if (wen_sram) wens++;
        if (mstrb_sdram) begin
          if (wr_rd_sdram) begin
            if (wbs == 0) wf = Address_sdram;
            wl = Address_sdram;
            wbs++;
          end else begin
            if (fills == 0) ff = Address_sdram;
            fl = Address_sdram;
            fills++;
          end
        end
        if (cpu.rdy_cpu && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("din", cpu.DIn_cpu, e.din);
            chk("busy_cycles", busy, e.busy);
            chk("fill_beats", fills, e.fills);
            if (e.fills > 0) begin
              chk("fill_first", ff, e.fill_first);
              chk("fill_last", fl, e.fill_first + 16'd31);
            end
            chk("wb_beats", wbs, e.wbs);
            if (e.wbs > 0) begin
              chk("wb_first", wf, e.wb_first);
              chk("wb_last", wl, e.wb_first + 16'd31);
            end
            chk("sram_writes", wens, e.wens);
          end
          busy = 0; fills = 0; wbs = 0; wens = 0;
        end
        prev_rdy = cpu.rdy_cpu;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic w, input exp_t e);
    int n = 0;
    while (!cpu.rdy_cpu && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("rdy_timeout", 0, 1);
    exp_q.push_back(e);
    cpu.Address_cpu = a;
    cpu.DOut_cpu    = d;
    cpu.wr_rd_cpu   = w;
    cpu.cs_cpu      = 1'b1;
    @(negedge clk);
    cpu.cs_cpu = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("completion_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    int act;
    rst = 1'b1;
    cpu.Address_cpu = '0;
    cpu.DOut_cpu    = '0;
    cpu.wr_rd_cpu   = 1'b0;
    cpu.cs_cpu      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", cpu.rdy_cpu, 0);
    chk("rst_din", cpu.DIn_cpu, 0);
    chk("rst_addr_sdram", Address_sdram, 0);
    chk("rst_strobes", {mstrb_sdram, wen_sram, mux_sel, demux_sel, wr_rd_sdram}, 0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rdy_after_release", cpu.rdy_cpu, 1);
    for (int i = 0; i < 8; i++) chk("rst_cache_line", dut.controller.cache_line[i], 0);
    @(negedge clk);
    mon_en = 1'b1;

    // Clean miss read
    issue(16'h1234, 8'h00, 1'b0, mk(8'h34, 34, 32, 16'h1220, 0, 16'h0, 32));
    chk("line1_after_fill", dut.controller.cache_line[1], 10'h212);

    // Write hit marks the line dirty; DIn_cpu holds the previous read
    issue(16'h1234, 8'hAB, 1'b1, mk(8'h34, 2, 0, 16'h0, 0, 16'h0, 1));
    chk("sram_1_20", dut.cache_memory.mem[1][20], 8'hAB);
    chk("line1_dirty", dut.controller.cache_line[1], 10'h312);

    // Dirty miss: write back tag 12 then fill tag 56
    issue(16'h5634, 8'h00, 1'b0, mk(8'h34, 66, 32, 16'h5620, 32, 16'h1220, 32));
    chk("sdram_1234", dut.sdram.mem[16'h1234], 8'hAB);
    chk("line1_tag56", dut.controller.cache_line[1], 10'h256);

    // Clean miss brings back the written-back byte
    issue(16'h1234, 8'h00, 1'b0, mk(8'hAB, 34, 32, 16'h1220, 0, 16'h0, 32));
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 1);
    chk("miss_count", miss_count, 3);
`endif

    // Read hit on a neighbouring byte
    issue(16'h1235, 8'h00, 1'b0, mk(8'h35, 2, 0, 16'h0, 0, 16'h0, 0));

    // Idle with cs_cpu low: no activity, addresses hold
    act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mstrb_sdram || wen_sram || !cpu.rdy_cpu) act++;
    end
    chk("idle_quiet", act, 0);
    chk("sram_addr_hold", address_cache_ctrl_sram, 8'h35);
    chk("sdram_addr_hold", Address_sdram, 16'h123F);
    chk("din_hold", cpu.DIn_cpu, 8'h35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_top.md
Name: cache_top

Overview:
- Direct-mapped write-back cache subsystem between a CPU request generator and a byte-wide SDRAM.
- Contains the controller FSM, the tag/valid/dirty array (instance `controller`, array `cache_line`), the SRAM data store (instance `cache_memory`, array `mem[DEPTH][32]`) and a behavioural SDRAM model.
- The CPU issues one request at a time when `rdy_cpu` is high; the block services hits from SRAM and misses via block transfer from SDRAM.

Parameters:
- ADDR_WIDTH, 16, CPU/SDRAM byte address width
- DATA_WIDTH, 8, data byte width
- ADDR_WIDTH_SRAM, 8, SRAM address width = {index[2:0], offset[4:0]}
- TAG_SIZE, 8, tag width (Address[15:8])
- DEPTH, 8, number of cache lines (index = Address[7:5]); block = 32 bytes (offset = Address[4:0])

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Address_cpu  in  16  CPU byte address
- DOut_cpu  in  8  CPU write data
- wr_rd_cpu  in  1  1 = write, 0 = read
- cs_cpu  in  1  request strobe
- rdy_cpu  out  1  high = idle, accepting a request
- DIn_cpu  out  8  read data to CPU, registered
- Address_sdram  out  16  SDRAM byte address
- wr_rd_sdram  out  1  1 = SDRAM write, 0 = read
- mstrb_sdram  out  1  SDRAM beat strobe
- mux_sel  out  1  SRAM write-data source: 0 = DOut_cpu, 1 = SDRAM
- demux_sel  out  1  SRAM read-data destination: 0 = CPU, 1 = SDRAM
- wen_sram  out  1  SRAM write enable
- address_cache_ctrl_sram  out  8  SRAM address

Behaviour:
- cache_line[i] layout: bit TAG_SIZE+1 = valid, bit TAG_SIZE = dirty, bits [TAG_SIZE-1:0] = tag.
- Reset (async):
  - all cache_line entries = 0; FSM enters INIT.
  - All outputs 0, including rdy_cpu and DIn_cpu.
  - SRAM data is not reset.
- SDRAM model: 64K x 8, initialised so that byte at address a = a[7:0].
  - Written on a clk edge when mstrb_sdram=1 and wr_rd_sdram=1.
  - Read combinationally.
- SRAM: written on a clk edge when wen_sram=1; read combinationally.
- States: INIT, IDLE, COMPARE, WRITEBACK, ALLOCATE, ACCESS.
  - INIT → IDLE after 1 cycle.
  - rdy_cpu is high only in IDLE.
- IDLE: if cs_cpu=1, latch address, data and wr_rd → COMPARE. cs_cpu is ignored in all other states.
- COMPARE: hit = valid && tag match.
  - hit → ACCESS
  - miss with valid && dirty → WRITEBACK
  - otherwise → ALLOCATE
- WRITEBACK: 32 beats, k = 0..31, one per cycle.
  - Address_sdram = {old_tag, index, k}; wr_rd_sdram=1; mstrb_sdram=1.
  - demux_sel=1; wen_sram=0; SRAM address = {index, k}.
  - → ALLOCATE.
- ALLOCATE: 32 beats.
  - Address_sdram = {new_tag, index, k}; wr_rd_sdram=0; mstrb_sdram=1.
  - mux_sel=1; wen_sram=1; SRAM address = {index, k}.
  - On the last beat, cache_line[index] = {valid=1, dirty=0, new_tag}.
  - → ACCESS.
- ACCESS (1 cycle): SRAM address = {index, offset}.
  - Write: mux_sel=0, wen_sram=1, dirty bit set.
  - Read: demux_sel=0, DIn_cpu <= SRAM byte.
  - → IDLE.
- Timing:
  - Hit: rdy_cpu low for exactly 2 cycles (COMPARE, ACCESS).
  - Clean miss: 34 cycles.
  - Dirty miss: 66 cycles.
- Outside their active states: mstrb_sdram, wen_sram, mux_sel, demux_sel and wr_rd_sdram are 0. Address outputs hold their last values.
- DIn_cpu holds its value until the next read completes.
- Reset mid-transfer: aborts immediately. A partially filled line stays invalid because it is only marked valid on the last ALLOCATE beat.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments by 1 in COMPARE, saturating at 0xFFFF.
  - Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then release → all 8 cache_line entries read 0; rdy_cpu=1 on the second clock after release.
- Read 0x1234 (tag 12, index 1, offset 14) → 32 ALLOCATE beats with Address_sdram 0x1220..0x123F and mstrb_sdram high for 32 cycles; DIn_cpu=0x34; line 1 = valid 1, dirty 0, tag 12.
- Write 0x1234 with data 0xAB → hit; no mstrb_sdram; rdy_cpu low 2 cycles; mem[1][20]=AB; line 1 dirty=1.
- Read 0x5634 → WRITEBACK of 0x1220..0x123F with wr_rd_sdram=1 (SDRAM[0x1234]=AB), then fill from 0x5620..0x563F; DIn_cpu=0x34; line 1 tag 56, dirty 0.
- Read 0x1234 → clean miss; DIn_cpu=0xAB.
- cs_cpu=0 while rdy_cpu=1 → FSM stays in IDLE, no SDRAM or SRAM activity; with CACHE_STATS_EN, counts after the sequence above are hits=1, misses=3.
